// File: rtl/vx_fpu_tag_tracker_pkg.sv
// Shared constants and types for the FPU tag tracker.
// Optional feature macro: FPU_TAG_CHECK_EN (checked responses, sticky tag_err).
package vx_fpu_tag_tracker_pkg;

    localparam int NUM_LANES_DEF  = 4;
    localparam int NUM_TAGS_DEF   = 8;
    localparam int META_WIDTH_DEF = 16;
    localparam int INST_FRM_BITS  = 3;
    localparam int FP_FLAGS_BITS  = 5;

    // IEEE exception flags as merged by the FPU units
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } fflags_t;

    // Tag-table entry at the default widths
    typedef struct packed {
        logic [META_WIDTH_DEF-1:0] meta;
        logic [NUM_LANES_DEF-1:0]  mask;
    } tag_entry_t;

    // Bit width needed to index n items, never less than 1
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_fpu_tag_tracker_tag_alloc.sv
// Busy bitmask with lowest-free allocation, single free port and popcount.
// Optional feature macro: FPU_TAG_CHECK_EN (not used in this file).
module vx_fpu_tag_tracker_tag_alloc
    import vx_fpu_tag_tracker_pkg::*;
#(
    parameter  int NUM_TAGS = NUM_TAGS_DEF,
    localparam int TAGW     = log2up(NUM_TAGS),
    localparam int CNTW     = log2up(NUM_TAGS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_alloc,
    output logic [TAGW-1:0]     o_alloc_tag,
    output logic                o_any_free,
    input  logic                i_free,
    input  logic [TAGW-1:0]     i_free_tag,
    output logic [NUM_TAGS-1:0] o_busy,
    output logic [CNTW-1:0]     o_count
);

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_alloc_oh;
    logic [NUM_TAGS-1:0] w_free_oh;
    logic [TAGW-1:0]     w_tag;
    logic                w_found;
    logic [CNTW-1:0]     w_cnt;

    // Lowest-index free tag: scan downward so the smallest index wins
    always_comb begin
        w_tag   = '0;
        w_found = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_tag   = TAGW'(i);
                w_found = 1'b1;
            end
        end
    end

    // Number of tags in flight
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_cnt = w_cnt + CNTW'(r_busy[i]);
        end
    end

    assign w_alloc_oh  = i_alloc ? (NUM_TAGS'(1) << w_tag) : '0;
    assign w_free_oh   = i_free ? (NUM_TAGS'(1) << i_free_tag) : '0;
    assign o_alloc_tag = w_tag;
    assign o_any_free  = w_found;
    assign o_busy      = r_busy;
    assign o_count     = w_cnt;

    // Clear then set, so a same-cycle alloc and free both land
    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= (r_busy & ~w_free_oh) | w_alloc_oh;
    end

endmodule

// File: rtl/vx_fpu_tag_tracker.sv
// Tags FPU requests, keeps per-tag metadata/mask and re-attaches them to
// out-of-order responses. Optional feature macro: FPU_TAG_CHECK_EN drops
// responses on free tags and raises sticky tag_err.
module vx_fpu_tag_tracker
    import vx_fpu_tag_tracker_pkg::*;
#(
    parameter  int NUM_LANES  = NUM_LANES_DEF,
    parameter  int NUM_TAGS   = NUM_TAGS_DEF,
    parameter  int META_WIDTH = META_WIDTH_DEF,
    localparam int TAGW       = log2up(NUM_TAGS),
    localparam int CNTW       = log2up(NUM_TAGS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_in,
    output logic                     req_ready_in,
    input  logic [NUM_LANES-1:0]     req_mask,
    input  logic [INST_FRM_BITS-1:0] req_frm,
    input  logic [NUM_LANES*32-1:0]  req_dataa,
    input  logic [META_WIDTH-1:0]    req_meta,
    output logic                     fpu_valid,
    input  logic                     fpu_ready,
    output logic [NUM_LANES-1:0]     fpu_mask,
    output logic [INST_FRM_BITS-1:0] fpu_frm,
    output logic [NUM_LANES*32-1:0]  fpu_dataa,
    output logic [TAGW-1:0]          fpu_tag,
    input  logic                     fpu_rsp_valid,
    output logic                     fpu_rsp_ready,
    input  logic [TAGW-1:0]          fpu_rsp_tag,
    input  logic [NUM_LANES*32-1:0]  fpu_rsp_result,
    input  logic                     fpu_rsp_has_fflags,
    input  logic [FP_FLAGS_BITS-1:0] fpu_rsp_fflags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [META_WIDTH-1:0]    rsp_meta,
    output logic [NUM_LANES-1:0]     rsp_mask,
    output logic [NUM_LANES*32-1:0]  rsp_result,
    output logic [FP_FLAGS_BITS-1:0] rsp_fflags,
    output logic [CNTW-1:0]          pending_count,
    output logic                     tag_err
);

    typedef struct packed {
        logic [META_WIDTH-1:0] meta;
        logic [NUM_LANES-1:0]  mask;
    } w_entry_t;

    logic [NUM_TAGS-1:0] w_busy;
    logic [TAGW-1:0]     w_alloc_tag;
    logic                w_any_free;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_rsp_fwd;
    logic                w_tag_busy;
    logic                w_free;
    w_entry_t            w_rd_entry;
    w_entry_t            r_table [NUM_TAGS];

    logic                     r_fpu_valid;
    logic [NUM_LANES-1:0]     r_fpu_mask;
    logic [INST_FRM_BITS-1:0] r_fpu_frm;
    logic [NUM_LANES*32-1:0]  r_fpu_dataa;
    logic [TAGW-1:0]          r_fpu_tag;

    logic                     r_rsp_valid;
    logic [META_WIDTH-1:0]    r_rsp_meta;
    logic [NUM_LANES-1:0]     r_rsp_mask;
    logic [NUM_LANES*32-1:0]  r_rsp_result;
    fflags_t                  r_rsp_fflags;

    assign req_ready_in  = w_any_free & (~r_fpu_valid | fpu_ready);
    assign w_req_fire    = req_valid_in & req_ready_in;
    assign fpu_rsp_ready = ~r_rsp_valid | rsp_ready;
    assign w_rsp_fire    = fpu_rsp_valid & fpu_rsp_ready;
    assign w_tag_busy    = w_busy[fpu_rsp_tag];
    // Clearing an already-free bit is a no-op, so gating by busy is safe in both builds
    assign w_free        = w_rsp_fire & w_tag_busy;
    assign w_rd_entry    = r_table[fpu_rsp_tag];

`ifdef FPU_TAG_CHECK_EN
    logic r_tag_err;

    assign w_rsp_fwd = w_rsp_fire & w_tag_busy;
    assign tag_err   = r_tag_err;

    // Sticky flag for a response arriving on a tag that is not in flight
    always_ff @(posedge clk) begin
        if (reset)                         r_tag_err <= 1'b0;
        else if (w_rsp_fire & ~w_tag_busy) r_tag_err <= 1'b1;
    end

    a_rsp_tag_busy: assert property (@(posedge clk) disable iff (reset)
        !(w_rsp_fire && !w_tag_busy))
        else $error("fpu response on free tag %0d", fpu_rsp_tag);
`else
    assign w_rsp_fwd = w_rsp_fire;
    assign tag_err   = 1'b0;
`endif

    vx_fpu_tag_tracker_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_alloc (
        .clk         (clk),
        .reset       (reset),
        .i_alloc     (w_req_fire),
        .o_alloc_tag (w_alloc_tag),
        .o_any_free  (w_any_free),
        .i_free      (w_free),
        .i_free_tag  (fpu_rsp_tag),
        .o_busy      (w_busy),
        .o_count     (pending_count)
    );

    // Table entries change only on allocation; reads are asynchronous
    always_ff @(posedge clk) begin
        if (w_req_fire) r_table[w_alloc_tag] <= '{meta: req_meta, mask: req_mask};
    end

    // Issue-side valid: set on accept, dropped once the unit takes it
    always_ff @(posedge clk) begin
        if (reset)           r_fpu_valid <= 1'b0;
        else if (w_req_fire) r_fpu_valid <= 1'b1;
        else if (fpu_ready)  r_fpu_valid <= 1'b0;
    end

    // Issue-side payload, held while the unit stalls
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_fpu_mask  <= req_mask;
            r_fpu_frm   <= req_frm;
            r_fpu_dataa <= req_dataa;
            r_fpu_tag   <= w_alloc_tag;
        end
    end

    // Commit-side valid: one-entry output register
    always_ff @(posedge clk) begin
        if (reset)          r_rsp_valid <= 1'b0;
        else if (w_rsp_fwd) r_rsp_valid <= 1'b1;
        else if (rsp_ready) r_rsp_valid <= 1'b0;
    end

    // Commit-side payload with metadata re-attached from the table
    always_ff @(posedge clk) begin
        if (w_rsp_fwd) begin
            r_rsp_meta   <= w_rd_entry.meta;
            r_rsp_mask   <= w_rd_entry.mask;
            r_rsp_result <= fpu_rsp_result;
            r_rsp_fflags <= fpu_rsp_has_fflags ? fflags_t'(fpu_rsp_fflags) : '0;
        end
    end

    assign fpu_valid  = r_fpu_valid;
    assign fpu_mask   = r_fpu_mask;
    assign fpu_frm    = r_fpu_frm;
    assign fpu_dataa  = r_fpu_dataa;
    assign fpu_tag    = r_fpu_tag;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_meta   = r_rsp_meta;
    assign rsp_mask   = r_rsp_mask;
    assign rsp_result = r_rsp_result;
    assign rsp_fflags = r_rsp_fflags;

endmodule

// File: tb/tb_vx_fpu_tag_tracker.sv
// Self-checking bench for vx_fpu_tag_tracker: directed scenarios plus a
// randomized run against a behavioural model. Honors FPU_TAG_CHECK_EN.
module tb_vx_fpu_tag_tracker;

    localparam int NL = 4;
    localparam int NT = 8;
    localparam int MW = 16;
    localparam int TW = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid_in, req_ready_in;
    logic [NL-1:0]   req_mask;
    logic [2:0]      req_frm;
    logic [NL*32-1:0] req_dataa;
    logic [MW-1:0]   req_meta;
    logic            fpu_valid, fpu_ready;
    logic [NL-1:0]   fpu_mask;
    logic [2:0]      fpu_frm;
    logic [NL*32-1:0] fpu_dataa;
    logic [TW-1:0]   fpu_tag;
    logic            fpu_rsp_valid, fpu_rsp_ready;
    logic [TW-1:0]   fpu_rsp_tag;
    logic [NL*32-1:0] fpu_rsp_result;
    logic            fpu_rsp_has_fflags;
    logic [4:0]      fpu_rsp_fflags;
    logic            rsp_valid, rsp_ready;
    logic [MW-1:0]   rsp_meta;
    logic [NL-1:0]   rsp_mask;
    logic [NL*32-1:0] rsp_result;
    logic [4:0]      rsp_fflags;
    logic [CW-1:0]   pending_count;
    logic            tag_err;

    always #5 clk = ~clk;

    vx_fpu_tag_tracker dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_ready_in(req_ready_in),
        .req_mask(req_mask), .req_frm(req_frm), .req_dataa(req_dataa), .req_meta(req_meta),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_mask(fpu_mask), .fpu_frm(fpu_frm),
        .fpu_dataa(fpu_dataa), .fpu_tag(fpu_tag),
        .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_ready(fpu_rsp_ready), .fpu_rsp_tag(fpu_rsp_tag),
        .fpu_rsp_result(fpu_rsp_result), .fpu_rsp_has_fflags(fpu_rsp_has_fflags),
        .fpu_rsp_fflags(fpu_rsp_fflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_meta(rsp_meta), .rsp_mask(rsp_mask),
        .rsp_result(rsp_result), .rsp_fflags(rsp_fflags),
        .pending_count(pending_count), .tag_err(tag_err)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: set of busy tags, metadata per tag, what sits on
    // each output interface, and the tags the FPU unit currently holds.
    bit              m_busy [NT];
    logic [MW-1:0]   m_meta [NT];
    logic [NL-1:0]   m_mask [NT];
    bit              m_fv, m_rv, m_err;
    int              m_ftag;
    logic [NL-1:0]   m_fmask, m_rmask;
    logic [2:0]      m_ffrm;
    logic [NL*32-1:0] m_fdata, m_rres;
    logic [MW-1:0]   m_rmeta;
    logic [4:0]      m_rflags;
    int              inflight [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NT; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic compare_state();
        chk("fpu_valid", fpu_valid, m_fv);
        if (m_fv) begin
            chk("fpu_tag", fpu_tag, m_ftag);
            chk("fpu_mask", fpu_mask, m_fmask);
            chk("fpu_frm", fpu_frm, m_ffrm);
            chk("fpu_dataa", fpu_dataa, m_fdata);
        end
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("rsp_meta", rsp_meta, m_rmeta);
            chk("rsp_mask", rsp_mask, m_rmask);
            chk("rsp_result", rsp_result, m_rres);
            chk("rsp_fflags", rsp_fflags, m_rflags);
        end
        chk("pending_count", pending_count, m_count());
        chk("tag_err", tag_err, m_err);
    endtask

    // One clock: inputs already driven; check handshakes, advance the model
    task automatic step();
        bit rdy, rrdy, qf, sf, fwd;
        int t, rt;
        #1;
        t    = m_lowest();
        rdy  = (t >= 0) && (!m_fv || fpu_ready);
        rrdy = !m_rv || rsp_ready;
        chk("req_ready_in", req_ready_in, rdy);
        chk("fpu_rsp_ready", fpu_rsp_ready, rrdy);
        qf = req_valid_in && rdy;
        sf = fpu_rsp_valid && rrdy;
        rt = int'(fpu_rsp_tag);
        if (m_fv && fpu_ready) inflight.push_back(m_ftag);
        fwd = sf;
`ifdef FPU_TAG_CHECK_EN
        if (sf && !m_busy[rt]) begin
            fwd   = 1'b0;
            m_err = 1'b1;
        end
`endif
        if (sf) begin
            for (int k = 0; k < inflight.size(); k++)
                if (inflight[k] == rt) begin inflight.delete(k); break; end
        end
        if (fwd) begin
            m_rv     = 1'b1;
            m_rmeta  = m_meta[rt];
            m_rmask  = m_mask[rt];
            m_rres   = fpu_rsp_result;
            m_rflags = fpu_rsp_has_fflags ? fpu_rsp_fflags : 5'h0;
        end else if (rsp_ready) m_rv = 1'b0;
        if (sf) m_busy[rt] = 1'b0;
        if (qf) begin
            m_busy[t] = 1'b1;
            m_meta[t] = req_meta;
            m_mask[t] = req_mask;
            m_fv      = 1'b1;
            m_ftag    = t;
            m_fmask   = req_mask;
            m_ffrm    = req_frm;
            m_fdata   = req_dataa;
        end else if (fpu_ready) m_fv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compare_state();
    endtask

    task automatic idle_inputs();
        req_valid_in = 0; req_mask = '0; req_frm = '0; req_dataa = '0; req_meta = '0;
        fpu_ready = 0; fpu_rsp_valid = 0; fpu_rsp_tag = '0; fpu_rsp_result = '0;
        fpu_rsp_has_fflags = 0; fpu_rsp_fflags = '0; rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
        m_fv = 0; m_rv = 0; m_err = 0;
        inflight.delete();
        compare_state();
        chk("rst_pending", pending_count, 0);
        chk("rst_fpu_valid", fpu_valid, 0);
    endtask

    task automatic send_req(input logic [MW-1:0] meta);
        req_valid_in = 1'b1;
        req_meta     = meta;
        req_mask     = meta[3:0];
        req_frm      = meta[2:0];
        req_dataa    = {4{16'h0, meta}};
    endtask

    task automatic send_rsp(input int tag, input bit has, input logic [4:0] fl);
        fpu_rsp_valid      = 1'b1;
        fpu_rsp_tag        = TW'(tag);
        fpu_rsp_has_fflags = has;
        fpu_rsp_fflags     = fl;
        fpu_rsp_result     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        do_reset();

        // Fill all tags back-to-back, then the 9th request stalls
        fpu_ready = 1; rsp_ready = 1;
        for (int i = 0; i < NT; i++) begin
            send_req(16'hA000 + 16'(i));
            step();
            chk("fill_tag", fpu_tag, i);
        end
        send_req(16'hA0FF);
        #1 chk("full_ready", req_ready_in, 0);
        step();
        chk("full_pending", pending_count, 8);
        req_valid_in = 0;

        // Out-of-order responses 5 then 2, with fflags masking
        send_rsp(5, 1'b0, 5'h1F);
        step();
        chk("ooo_meta5", rsp_meta, 16'hA005);
        chk("fflags_masked", rsp_fflags, 5'h00);
        send_rsp(2, 1'b1, 5'h1F);
        step();
        chk("ooo_meta2", rsp_meta, 16'hA002);
        chk("fflags_pass", rsp_fflags, 5'h1F);
        fpu_rsp_valid = 0;
        send_req(16'hB000);
        step();
        chk("realloc_2", fpu_tag, 2);
        send_req(16'hB001);
        step();
        chk("realloc_5", fpu_tag, 5);
        req_valid_in = 0;

        // Back-pressure on the commit side
        rsp_ready = 0;
        send_rsp(0, 1'b0, 5'h0);
        step();
        chk("hold_first", rsp_meta, 16'hA000);
        send_rsp(1, 1'b0, 5'h0);
        for (int i = 0; i < 2; i++) begin
            #1 chk("hold_rdy", fpu_rsp_ready, 0);
            step();
            chk("hold_meta", rsp_meta, 16'hA000);
        end
        rsp_ready = 1;
        step();
        chk("drain_1", rsp_meta, 16'hA001);
        send_rsp(3, 1'b0, 5'h0);
        step();
        chk("drain_3", rsp_meta, 16'hA003);
        fpu_rsp_valid = 0;
        step();

        // Response on a free tag after reset
        do_reset();
        rsp_ready = 1;
        send_rsp(6, 1'b0, 5'h0);
        step();
        fpu_rsp_valid = 0;
`ifdef FPU_TAG_CHECK_EN
        chk("free_tag_drop", rsp_valid, 0);
        chk("free_tag_err", tag_err, 1);
        step();
        chk("free_tag_sticky", tag_err, 1);
`else
        chk("free_tag_fwd", rsp_valid, 1);
        chk("free_tag_stale", rsp_meta, 16'hA006);
        step();
`endif

        // Same-cycle alloc and free with seven tags busy
        do_reset();
        fpu_ready = 1; rsp_ready = 1;
        for (int i = 0; i < NT - 1; i++) begin
            send_req(16'hC000 + 16'(i));
            step();
        end
        send_req(16'hC007);
        send_rsp(3, 1'b0, 5'h0);
        step();
        fpu_rsp_valid = 0;
        chk("same_pending", pending_count, 7);
        chk("same_tag7", fpu_tag, 7);
        chk("same_meta3", rsp_meta, 16'hC003);
        send_req(16'hC008);
        step();
        chk("same_reuse3", fpu_tag, 3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid_in       = ($urandom % 3) != 0;
            req_meta           = MW'($urandom);
            req_mask           = NL'($urandom);
            req_frm            = 3'($urandom);
            req_dataa          = {$urandom, $urandom, $urandom, $urandom};
            fpu_ready          = ($urandom % 4) != 0;
            rsp_ready          = ($urandom % 3) != 0;
            if (inflight.size() > 0 && ($urandom % 2) == 1) begin
                fpu_rsp_valid = 1'b1;
                fpu_rsp_tag   = TW'(inflight[$urandom_range(0, inflight.size() - 1)]);
            end else begin
                fpu_rsp_valid = 1'b0;
                fpu_rsp_tag   = TW'($urandom);
            end
            fpu_rsp_result     = {$urandom, $urandom, $urandom, $urandom};
            fpu_rsp_has_fflags = 1'($urandom);
            fpu_rsp_fflags     = 5'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
